// File: rtl/next_pc_sequencer_if.sv
// Control and address bundle between the decode stage / program counter
// and the next-PC sequencer.
interface next_pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] programCounter;
    logic             stall;
    logic             branch_taken;
    logic [15:0]      branch_offset;
    logic             jump;
    logic [25:0]      jump_target;
    logic             jr;
    logic [WIDTH-1:0] jr_target;
    logic             interrupt;
    logic             eret;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] epc;
    logic             int_ack;
    logic             in_handler;

    // Decode stage / PC register side: supplies controls, consumes the next PC.
    modport master (
        output programCounter, stall, branch_taken, branch_offset, jump,
               jump_target, jr, jr_target, interrupt, eret,
        input  address, epc, int_ack, in_handler
    );

    // Sequencer side.
    modport slave (
        input  programCounter, stall, branch_taken, branch_offset, jump,
               jump_target, jr, jr_target, interrupt, eret,
        output address, epc, int_ack, in_handler
    );
endinterface

// File: rtl/next_pc_sequencer.sv
// Next instruction address generation: increment, branch, jump, jump-register,
// stall, plus single-level interrupt entry and eret return through EPC.
module next_pc_sequencer #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] INT_VECTOR = WIDTH'(40)
) (
    input logic                  clock,
    input logic                  reset,
    next_pc_sequencer_if.slave   bus
);
    typedef enum logic {RUN, HANDLER} state_t;

    state_t           state_q, state_d;
    logic             pending_q;
    logic [WIDTH-1:0] epc_q;
    logic             int_ack_q;
    logic             in_handler_q;

    logic [WIDTH-1:0] pc1, br, jt, normal;
    logic             entry;

    always_comb begin
        pc1    = bus.programCounter + WIDTH'(1);
        br     = pc1 + {{(WIDTH-16){bus.branch_offset[15]}}, bus.branch_offset};
        jt     = {pc1[WIDTH-1:26], bus.jump_target};
        normal = bus.jr ? bus.jr_target : bus.jump ? jt : bus.branch_taken ? br : pc1;
    end

    // NOTE: every signal written below gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        bus.address = normal;
        entry       = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.stall) begin
                    bus.address = bus.programCounter;
                end else if (pending_q || bus.interrupt) begin
                    bus.address = INT_VECTOR;
                    entry       = 1'b1;
                    state_d     = HANDLER;
                end
            end
            HANDLER: begin
                // A stalled eret is simply dropped; decode re-presents it.
                if (bus.stall) begin
                    bus.address = bus.programCounter;
                end else if (bus.eret) begin
                    bus.address = epc_q;
                    state_d     = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RUN;
            pending_q    <= 1'b0;
            epc_q        <= '0;
            int_ack_q    <= 1'b0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_ack_q    <= entry;
            in_handler_q <= (state_d == HANDLER);
            if (entry) begin
                // Return point honours a branch/jump resolved in the entry cycle.
                epc_q     <= normal;
                pending_q <= 1'b0;
            end else if (state_q == RUN && bus.interrupt) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign bus.epc        = epc_q;
    assign bus.int_ack    = int_ack_q;
    assign bus.in_handler = in_handler_q;
endmodule

// File: tb/tb_next_pc_sequencer.sv
// Directed bench for next_pc_sequencer: expected values queued at stimulus
// time and popped when the corresponding DUT output is sampled.
module tb_next_pc_sequencer;
    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    next_pc_sequencer_if #(.WIDTH(32)) bus ();

    next_pc_sequencer #(.WIDTH(32), .INT_VECTOR(32'd40)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] observed);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h required an expected entry", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.stall = 0; bus.branch_taken = 0; bus.branch_offset = '0;
        bus.jump = 0; bus.jump_target = '0; bus.jr = 0; bus.jr_target = '0;
        bus.interrupt = 0; bus.eret = 0;
    endtask

    task automatic chk_addr(input string tag, input logic [31:0] value);
        #1;
        expect_val(tag, value);
        compare(bus.address);
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] epc_v,
                            input logic ack_v, input logic inh_v);
        expect_val({tag, "_epc"}, epc_v);
        compare(bus.epc);
        expect_val({tag, "_int_ack"}, {31'b0, ack_v});
        compare({31'b0, bus.int_ack});
        expect_val({tag, "_in_handler"}, {31'b0, inh_v});
        compare({31'b0, bus.in_handler});
    endtask

    initial begin
        idle();
        bus.programCounter = 32'hFFFF_FFFF;
        reset = 1;
        tick();
        chk_regs("reset", 32'd0, 1'b0, 1'b0);
        reset = 0;

        // Sequential increment and wrap
        bus.programCounter = 32'hFFFF_FFFF; chk_addr("seq_wrap_after_reset", 32'd0);
        bus.programCounter = 32'd5;         chk_addr("seq_inc", 32'd6);
        tick();
        bus.programCounter = 32'hFFFF_FFFF; chk_addr("seq_wrap", 32'd0);
        tick();

        // Branch / jump / jr priority
        bus.programCounter = 32'd10; bus.branch_taken = 1; bus.branch_offset = 16'hFFFD;
        chk_addr("branch_neg", 32'd8);
        bus.jump = 1; bus.jump_target = 26'd100;
        chk_addr("jump_over_branch", 32'd100);
        bus.jr = 1; bus.jr_target = 32'd77;
        chk_addr("jr_over_jump", 32'd77);
        tick();
        idle();
        chk_regs("no_entry_on_controls", 32'd0, 1'b0, 1'b0);

        // Interrupt entry, plain
        bus.programCounter = 32'd20; bus.interrupt = 1;
        chk_addr("entry_vector", 32'd40);
        tick();
        bus.interrupt = 0;
        chk_regs("entry", 32'd21, 1'b1, 1'b1);
        bus.programCounter = 32'd40; chk_addr("handler_seq", 32'd41);
        tick();
        chk_regs("entry_plus2", 32'd21, 1'b0, 1'b1);
        bus.programCounter = 32'd41; bus.eret = 1;
        chk_addr("eret_plain", 32'd21);
        tick();
        bus.eret = 0;
        chk_regs("after_eret_plain", 32'd21, 1'b0, 1'b0);

        // Entry with branch in the same cycle
        bus.programCounter = 32'd30; bus.branch_taken = 1; bus.branch_offset = 16'd5;
        bus.interrupt = 1;
        chk_addr("entry_branch_vector", 32'd40);
        tick();
        idle();
        chk_regs("entry_branch", 32'd36, 1'b1, 1'b1);
        bus.programCounter = 32'd41; bus.eret = 1;
        chk_addr("eret_to_branch", 32'd36);
        tick();
        bus.eret = 0;
        chk_regs("after_eret_branch", 32'd36, 1'b0, 1'b0);

        // eret in RUN is ignored
        bus.programCounter = 32'd50; bus.eret = 1;
        chk_addr("eret_in_run", 32'd51);
        tick();
        bus.eret = 0;
        chk_regs("eret_in_run", 32'd36, 1'b0, 1'b0);

        // Stall defers entry, pending retained
        bus.programCounter = 32'd12; bus.stall = 1; bus.interrupt = 1;
        chk_addr("stall_hold", 32'd12);
        tick();
        bus.interrupt = 0;
        chk_regs("stall_no_entry", 32'd36, 1'b0, 1'b0);
        bus.stall = 0;
        chk_addr("pending_entry", 32'd40);
        tick();
        chk_regs("pending_entry", 32'd13, 1'b1, 1'b1);

        // Stall defers eret in HANDLER
        bus.programCounter = 32'd44; bus.stall = 1; bus.eret = 1;
        chk_addr("handler_stall", 32'd44);
        tick();
        idle();
        chk_regs("handler_stall", 32'd13, 1'b0, 1'b1);

        // Interrupt masked inside the handler
        bus.programCounter = 32'd45; bus.interrupt = 1;
        chk_addr("masked_seq", 32'd46);
        tick();
        chk_regs("masked_1", 32'd13, 1'b0, 1'b1);
        tick();
        chk_regs("masked_2", 32'd13, 1'b0, 1'b1);

        // eret wins over interrupt; interrupt taken later in RUN
        bus.programCounter = 32'd46; bus.eret = 1;
        chk_addr("eret_over_int", 32'd13);
        tick();
        bus.eret = 0;
        chk_regs("eret_over_int", 32'd13, 1'b0, 1'b0);
        bus.programCounter = 32'd13;
        chk_addr("reentry_vector", 32'd40);
        tick();
        chk_regs("reentry", 32'd14, 1'b1, 1'b1);

        // Reset mid-handler
        reset = 1;
        tick();
        reset = 0; bus.interrupt = 0;
        chk_regs("reset_in_handler", 32'd0, 1'b0, 1'b0);
        bus.programCounter = 32'd60;
        chk_addr("after_reset_no_pending", 32'd61);
        tick();
        chk_regs("after_reset_idle", 32'd0, 1'b0, 1'b0);

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/next_pc_sequencer.md
Name: next_pc_sequencer

Overview:
- Computes the next instruction address each cycle and drives the `address` input of the program counter register.
- Sits directly upstream of the program counter. Takes the current `programCounter` value back and combines it with decode-stage control: sequential increment, conditional branch, jump, jump-register, stall.
- Owns interrupt entry and return: latches a pending interrupt, vectors to the handler, saves the return address in EPC, and restores it on `eret`.
- Addresses are word indices (increment by 1).

Parameters:
- INT_VECTOR, 32'd40, word address of the interrupt handler's first instruction.
- WIDTH, 32, address width. All arithmetic is modulo 2^WIDTH.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- programCounter  in  32  current PC value (output of the program counter register).
- stall  in  1  hold the current PC.
- branch_taken  in  1  conditional branch resolved taken.
- branch_offset  in  16  signed word offset, relative to PC+1.
- jump  in  1  absolute jump.
- jump_target  in  26  jump target, low 26 bits.
- jr  in  1  jump to register.
- jr_target  in  32  register-supplied target.
- interrupt  in  1  level interrupt request.
- eret  in  1  return from interrupt.
- address  out  32  next PC (combinational), to the program counter `address` input.
- epc  out  32  saved return address (registered).
- int_ack  out  1  one-cycle pulse on interrupt entry (registered).
- in_handler  out  1  high while the FSM is in HANDLER (registered).

Behaviour:
- Reset (synchronous, on posedge with reset=1):
  - state=RUN, pending=0, epc=0, int_ack=0, in_handler=0.
  - `address` stays combinational; the downstream PC ignores it during reset.
- Internal values:
  - pc1 = programCounter+1, wrapping (0xFFFFFFFF -> 0).
  - br = pc1 + sign_extend(branch_offset), modulo 2^32.
  - jt = {pc1[31:26], jump_target}.
  - normal = jr ? jr_target : jump ? jt : branch_taken ? br : pc1. Priority is jr > jump > branch > increment.
- pending flag:
  - Set on any non-reset cycle with interrupt=1 while state=RUN.
  - Cleared on the entry cycle.
  - interrupt is ignored (not latched) in HANDLER.
- FSM states: RUN, HANDLER.
- RUN:
  - stall=1: address=programCounter. No state change. Entry is deferred and pending is held.
  - else if (pending | interrupt): entry cycle.
    - address=INT_VECTOR.
    - epc<=normal, so a branch/jump in the same cycle is preserved as the return point.
    - int_ack<=1 next cycle.
    - state<=HANDLER, pending<=0.
  - else: address=normal.
  - eret in RUN is ignored (address=normal, no effect).
- HANDLER:
  - stall=1: address=programCounter. eret is deferred and not registered.
  - eret=1 and stall=0: address=epc, state<=RUN. epc keeps its value.
  - else: address=normal. Branches and jumps work inside the handler.
- Output timing:
  - int_ack is high exactly one cycle, the cycle after entry.
  - in_handler equals (state==HANDLER), registered.
- Nesting: not supported. No second entry until eret returns the FSM to RUN.
- Simultaneous events:
  - interrupt together with jr/jump/branch in RUN: interrupt wins `address`; epc captures the branch/jump target.
  - interrupt together with eret in HANDLER: eret wins; the interrupt is not latched, and is taken on a later RUN cycle if still asserted.
- Reset mid-handler: state returns to RUN, epc=0, pending is lost.

Test Plan:
- Sequential: reset 1 cycle, programCounter=0xFFFFFFFF -> address=0; programCounter=5 -> address=6; programCounter=0xFFFFFFFF with no controls -> address=0 (wrap).
- Branch/jump priority: PC=10, branch_taken=1, offset=-3 -> address=8; PC=10, jump=1, jump_target=100, branch_taken=1 -> address=100; jr=1, jr_target=77 with jump=1 -> address=77.
- Interrupt entry: PC=20, interrupt pulse 1 cycle -> address=40 same cycle; next cycle epc=21, int_ack=1, in_handler=1; following cycle int_ack=0.
- Entry with branch: PC=30, branch_taken=1, offset=+5, interrupt=1 -> address=40, epc=36. Then PC=41, eret=1 -> address=36, in_handler=0 next cycle.
- Stall deferral: interrupt pulse while stall=1 at PC=12 -> address=12, no int_ack. Stall released (interrupt now 0) -> address=40, epc=13 (pending retained).
- Masking/reset: interrupt held high in HANDLER -> no second int_ack, epc unchanged. Assert reset in HANDLER -> in_handler=0, epc=0, int_ack=0 next cycle.
